mini_cpu_pipe: RTL and testbench
================================

MINI_CPU_PIPE -- requirements
Module: mini_cpu_pipe

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning register and ALU width.
REQ-002 SHALL have parameter REG_AW, default 8, meaning register address width; the register file has 2**REG_AW entries.
REQ-003 SHALL have parameter PC_W, default 16, meaning instruction address width.
REQ-004 SHALL have parameter STACK_DEPTH, default 4, meaning the number of call-stack entries (minimum 1).
REQ-005 SHALL have port Clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port Reset, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port oInstrAddr, output, PC_W bits: combinational fetch address to the external instruction ROM.
REQ-008 SHALL have port iInstruction, input, 4+3*REG_AW bits, fields op[top 4] | dst | src1 | src0: the combinational ROM data.
REQ-009 SHALL have port oLed, output, 8 bits: LED register.
REQ-010 SHALL have ports oVgaWe (1 bit), oVgaAddr (16 bits) and oVgaColor (3 bits), all outputs: the video-RAM write strobe, address and colour.
REQ-011 SHALL have port oStackErr, output, 1 bit: sticky call-stack overflow/underflow flag.

Function
REQ-012 SHALL be a two-stage pipeline.
- Fetch: the decode register captures iInstruction; register-file reads are addressed by the src0/src1 fields of iInstruction.
- Execute: decodes the registered op and uses the synchronous read data.
REQ-013 SHALL drive oInstrAddr = branch_taken ? target : PC and update PC <= oInstrAddr+1 every cycle; branches have zero bubble.
REQ-014 SHALL implement these ops:
- NOP=0, no effect.
- ADD=1: dst = s1+s0.
- STO=2: dst = {src1,src0} zero-extended.
- BLE=3: branch to dst if s1<=s0, unsigned.
- JMP=4: branch to dst.
- LED=5: oLed <= s1[7:0].
- SUB=6: dst = s1-s0.
- MUL=7: dst = low DATA_W bits of s1*s0.
- VGA=8: write.
- CALL=9: push, branch to dst.
- RTS=10: pop, branch to the popped address.
- Opcodes 11-15 behave as NOP.
REQ-015 SHALL wrap all arithmetic modulo 2**DATA_W; branch targets are the dst field zero-extended to PC_W.
REQ-016 SHALL commit register writes at the end of the execute cycle.
REQ-017 SHALL, for VGA, assert oVgaWe combinationally for one cycle with oVgaAddr = {s1[7:0], s0[7:0]} and oVgaColor = dst[2:0].
REQ-018 SHALL, for CALL, push PC (the address of CALL+1) onto the stack.
REQ-019 SHALL, for CALL on a full stack, discard the push, still take the branch, and set oStackErr.
REQ-020 SHALL, for RTS on an empty stack, take no branch, leave the stack pointer unchanged, and set oStackErr.
REQ-021 SHALL keep oStackErr set until Reset.

Reset
REQ-022 SHALL, on Reset, asynchronously clear PC, the decode register (to NOP), oLed, the stack pointer and oStackErr.
REQ-023 SHALL hold oInstrAddr=0 and oVgaWe=0 while Reset is asserted.
REQ-024 SHALL fetch address 0 on the first rising edge after Reset deasserts.
REQ-025 SHALL NOT reset register-file contents.
REQ-026 SHALL, when Reset is asserted mid-CALL, cancel that CALL with no push.

Configuration
REQ-027 SHALL, with MINI_CPU_PIPE_FWD_EN defined, forward the last committed result to any source operand whose address equals the previous instruction's dst, applied only when that instruction wrote the register file.
REQ-028 SHALL, without MINI_CPU_PIPE_FWD_EN, perform no forwarding; back-to-back dependent instructions then read the stale value, and software must insert a NOP.

Structure
REQ-029 SHALL place the opcode constants and the instruction field-position localparams in the shared package mini_cpu_pkg.
REQ-030 SHALL implement the LIFO return-address stack as the sub-module mini_cpu_call_stack, which has push, pop, full, empty and top outputs and is parametrised by STACK_DEPTH and PC_W.

Verification
REQ-031 SHALL cover: STO r1=5; STO r2=7; ADD r3=r1+r2; LED r3 -> oLed=0x0C with FWD_EN. Without FWD_EN and no NOPs, oLed differs.
REQ-032 SHALL cover: STO r1=3, STO r2=3, BLE to 0x20 -> next oInstrAddr=0x20 with no bubble. With r2=4 the branch is not taken and fetch is sequential.
REQ-033 SHALL cover: STACK_DEPTH=2, nested CALL A, CALL B, RTS, RTS -> returns land at B-caller+1 then A-caller+1, and oStackErr=0.
REQ-034 SHALL cover: a third nested CALL with STACK_DEPTH=2 -> branch taken, oStackErr=1. A lone RTS after reset -> no branch, oStackErr=1.
REQ-035 SHALL cover: SUB 0-1 with DATA_W=8 -> 0xFF. MUL 0x10*0x10 with DATA_W=8 -> 0x00.
REQ-036 SHALL cover: VGA with s1=0x12, s0=0x34, dst=0x05 -> oVgaWe pulse, oVgaAddr=0x1234, oVgaColor=5. Reset asserted mid-program -> oInstrAddr=0 immediately and oLed=0.

Source files
------------

// File: rtl/mini_cpu_pkg.sv
// Shared definitions for the mini CPU: the opcode set and where each instruction field sits.
package mini_cpu_pkg;

   localparam int OP_W = 4;

   // Field positions, counted in REG_AW-wide slots from the LSB; the opcode sits above dst.
   localparam int SRC0_SLOT = 0;
   localparam int SRC1_SLOT = 1;
   localparam int DST_SLOT  = 2;
   localparam int OP_SLOT   = 3;

   typedef enum logic [OP_W-1:0] {
      OP_NOP  = 4'd0,
      OP_ADD  = 4'd1,
      OP_STO  = 4'd2,
      OP_BLE  = 4'd3,
      OP_JMP  = 4'd4,
      OP_LED  = 4'd5,
      OP_SUB  = 4'd6,
      OP_MUL  = 4'd7,
      OP_VGA  = 4'd8,
      OP_CALL = 4'd9,
      OP_RTS  = 4'd10
   } opCodeT;

endpackage

// File: rtl/mini_cpu_call_stack.sv
// LIFO of return addresses; the caller decides what to do when it is full or empty.
module mini_cpu_call_stack #(
   parameter int STACK_DEPTH = 4,
   parameter int PC_W        = 16
) (
   input  logic            Clock,
   input  logic            Reset,
   input  logic            push,
   input  logic            pop,
   input  logic [PC_W-1:0] pushAddr,
   output logic            full,
   output logic            empty,
   output logic [PC_W-1:0] top
);

   localparam int SP_W  = $clog2(STACK_DEPTH + 1);
   localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

   logic [SP_W-1:0] sp;
   logic [PC_W-1:0] entries [STACK_DEPTH];

   assign full  = (sp == SP_W'(STACK_DEPTH));
   assign empty = (sp == '0);
   assign top   = entries[IDX_W'(sp - SP_W'(1))];

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         sp <= '0;
      end else if (push && !full) begin
         sp <= sp + SP_W'(1);
      end else if (pop && !empty) begin
         sp <= sp - SP_W'(1);
      end
   end

   // NOTE: storage arrays carry no reset; only the pointer defines which entries are valid.
   always_ff @(posedge Clock) begin
      if (push && !full) begin
         entries[IDX_W'(sp)] <= pushAddr;
      end
   end

endmodule

// File: rtl/mini_cpu_pipe.sv
// Two-stage (fetch / execute) mini CPU with zero-bubble branches and a return-address stack.
// Define MINI_CPU_PIPE_FWD_EN to forward the previous instruction's result to its successor.
module mini_cpu_pipe
   import mini_cpu_pkg::*;
#(
   parameter int DATA_W      = 32,
   parameter int REG_AW      = 8,
   parameter int PC_W        = 16,
   parameter int STACK_DEPTH = 4
) (
   input  logic                     Clock,
   input  logic                     Reset,
   output logic [PC_W-1:0]          oInstrAddr,
   input  logic [OP_W+3*REG_AW-1:0] iInstruction,
   output logic [7:0]               oLed,
   output logic                     oVgaWe,
   output logic [15:0]              oVgaAddr,
   output logic [2:0]               oVgaColor,
   output logic                     oStackErr
);

   localparam int INSTR_W = OP_W + 3*REG_AW;

   logic [INSTR_W-1:0] decodeReg;
   logic [PC_W-1:0]    pc;
   logic [DATA_W-1:0]  regFile [2**REG_AW];
   logic [DATA_W-1:0]  rdData0, rdData1, s0, s1, wrData;
   logic [REG_AW-1:0]  fetchSrc0, fetchSrc1, exDst;
   logic [PC_W-1:0]    branchAddr, stackTop;
   opCodeT             exOp;
   logic               regWe, branchTaken, push, pop, ledWe, errSet, stackFull, stackEmpty;

   assign fetchSrc0 = iInstruction[SRC0_SLOT*REG_AW +: REG_AW];
   assign fetchSrc1 = iInstruction[SRC1_SLOT*REG_AW +: REG_AW];
   assign exDst     = decodeReg[DST_SLOT*REG_AW +: REG_AW];
   assign exOp      = opCodeT'(decodeReg[OP_SLOT*REG_AW +: OP_W]);

   // Synchronous read: operands arrive in the execute cycle; a write on the same edge is not seen.
   always_ff @(posedge Clock) begin
      if (regWe) begin
         regFile[exDst] <= wrData;
      end
      rdData0 <= regFile[fetchSrc0];
      rdData1 <= regFile[fetchSrc1];
   end

`ifdef MINI_CPU_PIPE_FWD_EN
   logic [REG_AW-1:0] exSrc0, exSrc1, lastAddr;
   logic [DATA_W-1:0] lastData;
   logic              lastWe;

   assign exSrc0 = decodeReg[SRC0_SLOT*REG_AW +: REG_AW];
   assign exSrc1 = decodeReg[SRC1_SLOT*REG_AW +: REG_AW];

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         lastWe   <= 1'b0;
         lastAddr <= '0;
         lastData <= '0;
      end else begin
         lastWe   <= regWe;
         lastAddr <= exDst;
         lastData <= wrData;
      end
   end

   assign s0 = (lastWe && lastAddr == exSrc0) ? lastData : rdData0;
   assign s1 = (lastWe && lastAddr == exSrc1) ? lastData : rdData1;
`else
   assign s0 = rdData0;
   assign s1 = rdData1;
`endif

   // NOTE: every output of a combinational block gets a default first so no latch is inferred.
   always_comb begin
      regWe       = 1'b0;
      wrData      = '0;
      branchTaken = 1'b0;
      branchAddr  = PC_W'(exDst);
      push        = 1'b0;
      pop         = 1'b0;
      ledWe       = 1'b0;
      oVgaWe      = 1'b0;
      errSet      = 1'b0;
      case (exOp)
         OP_ADD: begin regWe = 1'b1; wrData = s1 + s0; end
         OP_STO: begin regWe = 1'b1; wrData = DATA_W'(decodeReg[2*REG_AW-1:0]); end
         OP_BLE: branchTaken = (s1 <= s0);
         OP_JMP: branchTaken = 1'b1;
         OP_LED: ledWe = 1'b1;
         OP_SUB: begin regWe = 1'b1; wrData = s1 - s0; end
         OP_MUL: begin regWe = 1'b1; wrData = s1 * s0; end
         OP_VGA: oVgaWe = 1'b1;
         OP_CALL: begin
            branchTaken = 1'b1;
            push        = !stackFull;
            errSet      = stackFull;
         end
         OP_RTS: begin
            branchTaken = !stackEmpty;
            pop         = !stackEmpty;
            errSet      = stackEmpty;
            branchAddr  = stackTop;
         end
         default: ;
      endcase
   end

   assign oInstrAddr = branchTaken ? branchAddr : pc;
   assign oVgaAddr   = {s1[7:0], s0[7:0]};
   assign oVgaColor  = exDst[2:0];

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         pc        <= '0;
         decodeReg <= '0;
         oLed      <= '0;
         oStackErr <= 1'b0;
      end else begin
         pc        <= oInstrAddr + PC_W'(1);
         decodeReg <= iInstruction;
         if (ledWe) begin
            oLed <= s1[7:0];
         end
         if (errSet) begin
            oStackErr <= 1'b1;
         end
      end
   end

   // pc already holds the CALL's address + 1 while the CALL executes.
   mini_cpu_call_stack #(
      .STACK_DEPTH(STACK_DEPTH),
      .PC_W       (PC_W)
   ) callStack (
      .Clock   (Clock),
      .Reset   (Reset),
      .push    (push),
      .pop     (pop),
      .pushAddr(pc),
      .full    (stackFull),
      .empty   (stackEmpty),
      .top     (stackTop)
   );

endmodule

// File: tb/tb_mini_cpu_pipe.sv
// Directed bench for mini_cpu_pipe (DATA_W=8, STACK_DEPTH=2) driving a ROM model from oInstrAddr.
module tb_mini_cpu_pipe;
   import mini_cpu_pkg::*;

   localparam int DATA_W = 8, REG_AW = 8, PC_W = 16, STACK_DEPTH = 2;
   localparam int IW = OP_W + 3*REG_AW;

   logic            Clock = 1'b0;
   logic            Reset = 1'b1;
   logic [PC_W-1:0] oInstrAddr;
   logic [IW-1:0]   iInstruction;
   logic [7:0]      oLed;
   logic            oVgaWe;
   logic [15:0]     oVgaAddr;
   logic [2:0]      oVgaColor;
   logic            oStackErr;

   logic [IW-1:0] rom [256];
   int testsRun = 0;
   int testsFailed = 0;

   assign iInstruction = (oInstrAddr < 16'd256) ? rom[oInstrAddr[7:0]] : '0;

   always #5 Clock = ~Clock;

   mini_cpu_pipe #(
      .DATA_W(DATA_W), .REG_AW(REG_AW), .PC_W(PC_W), .STACK_DEPTH(STACK_DEPTH)
   ) dut (
      .Clock(Clock), .Reset(Reset), .oInstrAddr(oInstrAddr), .iInstruction(iInstruction),
      .oLed(oLed), .oVgaWe(oVgaWe), .oVgaAddr(oVgaAddr), .oVgaColor(oVgaColor),
      .oStackErr(oStackErr)
   );

   function automatic logic [IW-1:0] ins(input opCodeT op, input int dst, input int s1, input int s0);
      return {op, REG_AW'(dst), REG_AW'(s1), REG_AW'(s0)};
   endfunction

   // Holds the CPU in reset and fills the ROM with NOPs; release() starts fetching at address 0.
   task automatic hold();
      Reset = 1'b1;
      for (int i = 0; i < 256; i++) rom[i] = '0;
   endtask

   task automatic release_cpu();
      @(negedge Clock);
      Reset = 1'b0;
   endtask

   task automatic test_reset();
      hold();
      #12;
      testsRun++;
      if (oInstrAddr !== 16'h0) begin testsFailed++; $display("FAIL reset_addr: got %h expected 0000", oInstrAddr); end
      testsRun++;
      if ({oVgaWe, oLed, oStackErr} !== 10'h0) begin
         testsFailed++; $display("FAIL reset_outputs: got we=%b led=%h err=%b expected all zero", oVgaWe, oLed, oStackErr);
      end
      release_cpu();
      testsRun++;
      if (oInstrAddr !== 16'h0) begin testsFailed++; $display("FAIL first_fetch: got %h expected 0000", oInstrAddr); end
      @(negedge Clock);
      testsRun++;
      if (oInstrAddr !== 16'h1) begin testsFailed++; $display("FAIL second_fetch: got %h expected 0001", oInstrAddr); end
   endtask

   task automatic test_forward();
      logic [7:0] expLed;
      // Seed r3 and r2 so the stale-read outcome is known.
      hold();
      rom[0] = ins(OP_STO, 3, 0, 8'h55);
      rom[1] = ins(OP_STO, 2, 0, 0);
      release_cpu();
      repeat (5) @(negedge Clock);
      // Back-to-back dependencies, no NOPs.
      hold();
      rom[0] = ins(OP_STO, 1, 0, 5);
      rom[1] = ins(OP_STO, 2, 0, 7);
      rom[2] = ins(OP_ADD, 3, 1, 2);
      rom[3] = ins(OP_LED, 0, 3, 0);
      release_cpu();
      repeat (8) @(negedge Clock);
`ifdef MINI_CPU_PIPE_FWD_EN
      expLed = 8'h0C;
`else
      expLed = 8'h55;
`endif
      testsRun++;
      if (oLed !== expLed) begin testsFailed++; $display("FAIL led_back_to_back: got %h expected %h", oLed, expLed); end
      // Same program with NOPs separating dependencies.
      hold();
      rom[0] = ins(OP_STO, 1, 0, 5);
      rom[1] = ins(OP_STO, 2, 0, 7);
      rom[3] = ins(OP_ADD, 3, 1, 2);
      rom[5] = ins(OP_LED, 0, 3, 0);
      release_cpu();
      repeat (8) @(negedge Clock);
      testsRun++;
      if (oLed !== 8'h0C) begin testsFailed++; $display("FAIL led_add_spaced: got %h expected 0c", oLed); end
   endtask

   task automatic test_branch();
      logic [7:0] r2Val [3] = '{8'd3, 8'd4, 8'd2};
      logic       taken [3] = '{1'b1, 1'b0, 1'b1};
      logic [15:0] exp;
      for (int i = 0; i < 3; i++) begin
         hold();
         rom[0] = ins(OP_STO, 1, 0, 3);
         rom[1] = ins(OP_STO, 2, 0, r2Val[i]);
         rom[3] = ins(OP_BLE, 8'h20, 2, 1);
         release_cpu();
         repeat (4) @(negedge Clock);
         exp = taken[i] ? 16'h0020 : 16'h0004;
         testsRun++;
         if (oInstrAddr !== exp) begin testsFailed++; $display("FAIL ble_target r2=%0d: got %h expected %h", r2Val[i], oInstrAddr, exp); end
         @(negedge Clock);
         exp = taken[i] ? 16'h0021 : 16'h0005;
         testsRun++;
         if (oInstrAddr !== exp) begin testsFailed++; $display("FAIL ble_next r2=%0d: got %h expected %h", r2Val[i], oInstrAddr, exp); end
      end
   endtask

   task automatic test_call_nest();
      logic [15:0] exp [5] = '{16'h0010, 16'h0020, 16'h0011, 16'h0001, 16'h0002};
      hold();
      rom[8'h00] = ins(OP_CALL, 8'h10, 0, 0);
      rom[8'h10] = ins(OP_CALL, 8'h20, 0, 0);
      rom[8'h11] = ins(OP_RTS, 0, 0, 0);
      rom[8'h20] = ins(OP_RTS, 0, 0, 0);
      release_cpu();
      for (int i = 0; i < 5; i++) begin
         @(negedge Clock);
         testsRun++;
         if (oInstrAddr !== exp[i]) begin testsFailed++; $display("FAIL call_trace step %0d: got %h expected %h", i, oInstrAddr, exp[i]); end
      end
      testsRun++;
      if (oStackErr !== 1'b0) begin testsFailed++; $display("FAIL call_nest_err: got %b expected 0", oStackErr); end
   endtask

   task automatic test_stack_err();
      logic [15:0] exp [4] = '{16'h0010, 16'h0020, 16'h0030, 16'h0011};
      hold();
      rom[8'h00] = ins(OP_CALL, 8'h10, 0, 0);
      rom[8'h10] = ins(OP_CALL, 8'h20, 0, 0);
      rom[8'h20] = ins(OP_CALL, 8'h30, 0, 0);
      rom[8'h30] = ins(OP_RTS, 0, 0, 0);
      release_cpu();
      for (int i = 0; i < 4; i++) begin
         @(negedge Clock);
         testsRun++;
         if (oInstrAddr !== exp[i]) begin testsFailed++; $display("FAIL overflow_trace step %0d: got %h expected %h", i, oInstrAddr, exp[i]); end
      end
      testsRun++;
      if (oStackErr !== 1'b1) begin testsFailed++; $display("FAIL overflow_err: got %b expected 1", oStackErr); end
      repeat (2) @(negedge Clock);
      testsRun++;
      if (oStackErr !== 1'b1) begin testsFailed++; $display("FAIL err_sticky: got %b expected 1", oStackErr); end
      // Lone RTS on an empty stack.
      hold();
      #1;
      testsRun++;
      if (oStackErr !== 1'b0) begin testsFailed++; $display("FAIL err_reset_clear: got %b expected 0", oStackErr); end
      rom[0] = ins(OP_RTS, 8'h40, 0, 0);
      release_cpu();
      @(negedge Clock);
      testsRun++;
      if (oInstrAddr !== 16'h0001) begin testsFailed++; $display("FAIL underflow_nobranch: got %h expected 0001", oInstrAddr); end
      @(negedge Clock);
      testsRun++;
      if (oStackErr !== 1'b1 || oInstrAddr !== 16'h0002) begin
         testsFailed++; $display("FAIL underflow_err: got err=%b addr=%h expected err=1 addr=0002", oStackErr, oInstrAddr);
      end
   endtask

   task automatic test_arith_wrap();
      hold();
      rom[0] = ins(OP_STO, 1, 0, 0);
      rom[1] = ins(OP_STO, 2, 0, 1);
      rom[3] = ins(OP_SUB, 4, 1, 2);
      rom[4] = {4'd13, REG_AW'(4), REG_AW'(0), REG_AW'(0)};
      rom[5] = ins(OP_LED, 0, 4, 0);
      release_cpu();
      repeat (8) @(negedge Clock);
      testsRun++;
      if (oLed !== 8'hFF) begin testsFailed++; $display("FAIL sub_wrap: got %h expected ff", oLed); end
      hold();
      rom[0] = ins(OP_STO, 1, 0, 8'h10);
      rom[1] = ins(OP_STO, 2, 0, 8'h10);
      rom[3] = ins(OP_LED, 0, 1, 0);
      rom[4] = ins(OP_MUL, 4, 1, 2);
      rom[6] = ins(OP_LED, 0, 4, 0);
      release_cpu();
      repeat (5) @(negedge Clock);
      testsRun++;
      if (oLed !== 8'h10) begin testsFailed++; $display("FAIL led_before_mul: got %h expected 10", oLed); end
      repeat (3) @(negedge Clock);
      testsRun++;
      if (oLed !== 8'h00) begin testsFailed++; $display("FAIL mul_wrap: got %h expected 00", oLed); end
   endtask

   task automatic test_vga_and_reset();
      hold();
      rom[0] = ins(OP_STO, 1, 0, 8'h12);
      rom[1] = ins(OP_STO, 2, 0, 8'h34);
      rom[3] = ins(OP_VGA, 5, 1, 2);
      rom[5] = ins(OP_LED, 0, 1, 0);
      rom[6] = ins(OP_JMP, 6, 0, 0);
      release_cpu();
      repeat (3) @(negedge Clock);
      testsRun++;
      if (oVgaWe !== 1'b0) begin testsFailed++; $display("FAIL vga_we_before: got %b expected 0", oVgaWe); end
      @(negedge Clock);
      testsRun++;
      if ({oVgaWe, oVgaAddr, oVgaColor} !== {1'b1, 16'h1234, 3'd5}) begin
         testsFailed++; $display("FAIL vga_write: got we=%b addr=%h col=%0d expected we=1 addr=1234 col=5", oVgaWe, oVgaAddr, oVgaColor);
      end
      @(negedge Clock);
      testsRun++;
      if (oVgaWe !== 1'b0) begin testsFailed++; $display("FAIL vga_we_after: got %b expected 0", oVgaWe); end
      repeat (3) @(negedge Clock);
      testsRun++;
      if (oLed !== 8'h12 || oInstrAddr !== 16'h0006) begin
         testsFailed++; $display("FAIL jmp_loop: got led=%h addr=%h expected led=12 addr=0006", oLed, oInstrAddr);
      end
      #2 Reset = 1'b1;
      #1;
      testsRun++;
      if (oInstrAddr !== 16'h0 || oLed !== 8'h00 || oVgaWe !== 1'b0) begin
         testsFailed++; $display("FAIL async_reset: got addr=%h led=%h we=%b expected 0000/00/0", oInstrAddr, oLed, oVgaWe);
      end
      // Reset lands while a CALL is executing; the push must not survive.
      hold();
      rom[8'h00] = ins(OP_CALL, 8'h10, 0, 0);
      release_cpu();
      @(negedge Clock);
      testsRun++;
      if (oInstrAddr !== 16'h0010) begin testsFailed++; $display("FAIL call_branch: got %h expected 0010", oInstrAddr); end
      #1 Reset = 1'b1;
      #1;
      testsRun++;
      if (oInstrAddr !== 16'h0) begin testsFailed++; $display("FAIL reset_mid_call: got %h expected 0000", oInstrAddr); end
      @(negedge Clock);
      rom[8'h00] = ins(OP_RTS, 0, 0, 0);
      Reset = 1'b0;
      @(negedge Clock);
      testsRun++;
      if (oInstrAddr !== 16'h0001) begin testsFailed++; $display("FAIL call_cancelled: got %h expected 0001", oInstrAddr); end
      @(negedge Clock);
      testsRun++;
      if (oStackErr !== 1'b1) begin testsFailed++; $display("FAIL call_cancelled_err: got %b expected 1", oStackErr); end
   endtask

   initial begin
      test_reset();
      test_forward();
      test_branch();
      test_call_nest();
      test_stack_err();
      test_arith_wrap();
      test_vga_and_reset();
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
